// File: rtl/axi_pkg.sv
// Shared AXI definitions for the on-chip RAM responder.
// Includes burst encodings, response codes, FSM state types and transfer-legality helpers.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    // Reserved burst 2'b11 walks like FIXED; it is flagged separately by xfer_err.
    function automatic logic burst_fixed(input logic [1:0] burst);
        return (burst != INCR) && (burst != WRAP);
    endfunction

    function automatic logic xfer_err(input logic [2:0] size, input logic [2:0] full_size,
                                      input logic [1:0] burst);
        return (size != full_size) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/axi_slave_ram_if.sv
// Full AXI4 channel set (AW/W/B/AR/R) between one master and one slave.
// Every channel moves a beat on a rising clk edge where valid and ready are both high; valid never waits on ready.
interface axi_bus_t #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 512,
    parameter int ID_W   = 4
);
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [ID_W-1:0]     awid;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [ID_W-1:0]     arid;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic [ID_W-1:0]     rid;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awid, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output araddr, arlen, arsize, arburst, arid, arvalid, input arready,
        input  rdata, rresp, rlast, rid, rvalid, output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awid, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  araddr, arlen, arsize, arburst, arid, arvalid, output arready,
        output rdata, rresp, rlast, rid, rvalid, input rready
    );
endinterface

// File: rtl/axi_skid_buf.sv
// Two-entry valid/ready pipeline register with registered outputs.
// The producer must only push when an entry is free; count reports occupancy for that decision.
module axi_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             pop;

    assign pop   = out_valid && out_ready;
    assign count = 2'(out_valid) + 2'(skid_valid);

    // The skid entry only fills while the head is held, so it is always the older of an in_data beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else if (pop || !out_valid) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= in_valid;
                if (in_valid) skid_data <= in_data;
            end else begin
                out_valid <= in_valid;
                if (in_valid) out_data <= in_data;
            end
        end else if (in_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end
endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 slave backed by a byte-enable simple dual-port RAM; one outstanding burst per direction.
// Reads go through a one-cycle RAM stage and a two-entry skid buffer that drives the R channel.
module axi_slave_ram
    import axi_pkg::*;
#(
    parameter int M_AXI_ADDR_WIDTH = 32,
    parameter int M_AXI_DATA_WIDTH = 512,
    parameter int M_AXI_ID_WIDTH   = 4,
    parameter int MEM_DEPTH        = 1024
) (
    input  logic    clk,
    input  logic    rst_n,
    axi_bus_t.slave s_axi,
    output logic    wr_busy,
    output logic    rd_busy
);
    localparam int         NB        = M_AXI_DATA_WIDTH / 8;
    localparam int         WORD_LSB  = $clog2(NB);
    localparam int         WORD_W    = $clog2(MEM_DEPTH);
    localparam logic [2:0] FULL_SIZE = 3'(WORD_LSB);
    localparam int         BUF_W     = M_AXI_ID_WIDTH + 3 + M_AXI_DATA_WIDTH;

    if (WORD_LSB + WORD_W > M_AXI_ADDR_WIDTH) begin : g_addr_too_narrow
        $error("axi_slave_ram: address bus too narrow for MEM_DEPTH");
    end

    wr_state_t                   w_state;
    logic [WORD_W-1:0]           w_word;
    logic [7:0]                  w_len, w_cnt;
    logic                        w_fixed, w_err, w_lerr;

    rd_state_t                   r_state;
    logic [WORD_W-1:0]           r_word;
    logic [7:0]                  r_len;
    logic [8:0]                  r_cnt;
    logic                        r_fixed, r_err;
    logic [M_AXI_ID_WIDTH-1:0]   r_id;

    logic [M_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [M_AXI_DATA_WIDTH-1:0] ram_q;
    logic                        mem_we, issue, r_pop, pipe_v, pipe_last;
    logic [1:0]                  buf_count;
    logic [2:0]                  in_flight;
    logic [BUF_W-1:0]            buf_in, buf_out;

    assign wr_busy = (w_state != W_IDLE);
    assign rd_busy = (r_state != R_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state       <= W_IDLE;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= OKAY;
            s_axi.bid     <= '0;
            w_word        <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_fixed       <= 1'b0;
            w_err         <= 1'b0;
            w_lerr        <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s_axi.awready <= 1'b1;
                    if (s_axi.awvalid && s_axi.awready) begin
                        s_axi.awready <= 1'b0;
                        s_axi.wready  <= 1'b1;
                        s_axi.bid     <= s_axi.awid;
                        w_word        <= s_axi.awaddr[WORD_LSB +: WORD_W];
                        w_len         <= s_axi.awlen;
                        w_cnt         <= '0;
                        w_fixed       <= burst_fixed(s_axi.awburst);
                        w_err         <= xfer_err(s_axi.awsize, FULL_SIZE, s_axi.awburst);
                        w_lerr        <= 1'b0;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi.wvalid && s_axi.wready) begin
                        w_cnt <= w_cnt + 8'd1;
                        if (!w_fixed) w_word <= w_word + 1'b1;
                        // The beat count, not wlast, closes the burst; a misplaced wlast only taints bresp.
                        if (w_cnt == w_len) begin
                            s_axi.wready <= 1'b0;
                            s_axi.bvalid <= 1'b1;
                            s_axi.bresp  <= (w_err || w_lerr || !s_axi.wlast) ? SLVERR : OKAY;
                            w_state      <= W_RESP;
                        end else if (s_axi.wlast) begin
                            w_lerr <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        s_axi.bvalid  <= 1'b0;
                        s_axi.awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign mem_we = s_axi.wvalid && s_axi.wready && !w_err;

    // Single block for both ports keeps same-word read/write read-first.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (s_axi.wstrb[i]) mem[w_word][i*8 +: 8] <= s_axi.wdata[i*8 +: 8];
            end
        end
        if (issue) ram_q <= mem[r_word];
    end

    // Beats already buffered or in the RAM stage, after this cycle's pop, must leave room for one more.
    assign r_pop     = s_axi.rvalid && s_axi.rready;
    assign in_flight = {1'b0, buf_count} + {2'b0, pipe_v} - {2'b0, r_pop};
    assign issue     = (r_state == R_DATA) && (r_cnt <= {1'b0, r_len}) && (in_flight < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= R_IDLE;
            s_axi.arready <= 1'b0;
            r_word        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_fixed       <= 1'b0;
            r_err         <= 1'b0;
            r_id          <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_axi.arready <= 1'b1;
                    if (s_axi.arvalid && s_axi.arready) begin
                        s_axi.arready <= 1'b0;
                        r_word        <= s_axi.araddr[WORD_LSB +: WORD_W];
                        r_len         <= s_axi.arlen;
                        r_cnt         <= '0;
                        r_fixed       <= burst_fixed(s_axi.arburst);
                        r_err         <= xfer_err(s_axi.arsize, FULL_SIZE, s_axi.arburst);
                        r_id          <= s_axi.arid;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (issue) begin
                        r_cnt <= r_cnt + 9'd1;
                        if (!r_fixed) r_word <= r_word + 1'b1;
                    end
                    if (r_pop && s_axi.rlast) begin
                        s_axi.arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v    <= 1'b0;
            pipe_last <= 1'b0;
        end else begin
            pipe_v    <= issue;
            pipe_last <= (r_cnt[7:0] == r_len);
        end
    end

    assign buf_in = {r_id, (r_err ? SLVERR : OKAY), pipe_last,
                     (r_err ? {M_AXI_DATA_WIDTH{1'b0}} : ram_q)};

    axi_skid_buf #(.WIDTH(BUF_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (pipe_v),
        .in_data   (buf_in),
        .out_valid (s_axi.rvalid),
        .out_ready (s_axi.rready),
        .out_data  (buf_out),
        .count     (buf_count)
    );

    assign {s_axi.rid, s_axi.rresp, s_axi.rlast, s_axi.rdata} = buf_out;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Bench for axi_slave_ram: directed bursts against a byte-level memory model.
// Expected R beats and B responses are queued at drive time and popped by channel monitors.
module tb_axi_slave_ram;
    import axi_pkg::*;

    localparam int DW    = 512;
    localparam int EXP_W = 4 + 2 + 1 + DW;

    logic clk;
    logic rst_n;
    logic wr_busy, rd_busy;
    int   checks   = 0;
    int   failures = 0;
    int   rr_mode  = 0;
    int   r_beats  = 0;
    bit   mon_off  = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [5:0]       b_q[$];
    logic [DW-1:0]    model [int];

    axi_bus_t #(.ADDR_W(32), .DATA_W(DW), .ID_W(4)) bus ();

    axi_slave_ram #(
        .M_AXI_ADDR_WIDTH (32),
        .M_AXI_DATA_WIDTH (DW),
        .M_AXI_ID_WIDTH   (4),
        .MEM_DEPTH        (1024)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_axi   (bus),
        .wr_busy (wr_busy),
        .rd_busy (rd_busy)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- drivers ----------------
    initial begin
        bus.rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       bus.rready = 1'b1;
                1:       bus.rready = ~bus.rready;
                default: bus.rready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ch: 0=AW 1=W 2=AR. Returns just after the handshake edge.
    task automatic wait_ready(input int ch, input string tag);
        int   n;
        logic rdy;
        bit   done;
        n    = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            case (ch)
                0:       rdy = bus.awready;
                1:       rdy = bus.wready;
                default: rdy = bus.arready;
            endcase
            if (rdy) done = 1;
            else begin
                n++;
                if (n > 200) begin
                    check({tag, "_timeout"}, DW'(0), DW'(1));
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b_drain();
        int n = 0;
        while (b_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (b_q.size() != 0) check("b_timeout", DW'(b_q.size()), DW'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_r_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("r_timeout", DW'(exp_q.size()), DW'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [3:0] id, input logic [DW-1:0] base,
                             input logic [63:0] strb, input int last_at);
        logic          err, fixed;
        int            word;
        logic [DW-1:0] d, tmp;
        err   = (size != 3'd6) || (burst == 2'b11);
        fixed = (burst == 2'b00) || (burst == 2'b11);
        word  = int'((addr >> 6) & 32'd1023);
        b_q.push_back({id, (err || last_at != int'(len)) ? SLVERR : OKAY});
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awsize  = size;
        bus.awburst = burst;
        bus.awid    = id;
        bus.awvalid = 1'b1;
        wait_ready(0, "aw");
        bus.awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            d          = base + DW'(k);
            bus.wdata  = d;
            bus.wstrb  = strb;
            bus.wlast  = (k == last_at);
            bus.wvalid = 1'b1;
            wait_ready(1, "w");
            if (!err) begin
                tmp = model.exists(word) ? model[word] : '0;
                for (int b = 0; b < 64; b++) if (strb[b]) tmp[b*8 +: 8] = d[b*8 +: 8];
                model[word] = tmp;
            end
            if (!fixed) word = (word + 1) % 1024;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        wait_b_drain();
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id);
        logic err, fixed;
        int   word, n;
        err   = (size != 3'd6) || (burst == 2'b11);
        fixed = (burst == 2'b00) || (burst == 2'b11);
        word  = int'((addr >> 6) & 32'd1023);
        for (int k = 0; k <= int'(len); k++) begin
            exp_q.push_back({id, err ? SLVERR : OKAY, 1'(k == int'(len)), err ? DW'(0) : model[word]});
            if (!fixed) word = (word + 1) % 1024;
        end
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arid    = id;
        bus.arvalid = 1'b1;
        wait_ready(2, "ar");
        bus.arvalid = 1'b0;
        n = 0;
        while (n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.rvalid) break;
        end
        check("r_latency", DW'(n), DW'(2));
        wait_r_drain();
    endtask

    // ---------------- monitors / scoreboard ----------------
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d;

    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst_n) hold_v = 1'b0;
        else begin
            if (hold_v) begin
                check("r_hold_valid", DW'(bus.rvalid), DW'(1));
                check("r_hold_data", bus.rdata, hold_d);
            end
            if (bus.rvalid && bus.rready) begin
                r_beats++;
                if (!mon_off) begin
                    if (exp_q.size() == 0) check("r_unexpected", DW'(1), DW'(0));
                    else begin
                        e = exp_q.pop_front();
                        check("r_data", bus.rdata, e[DW-1:0]);
                        check("r_last", DW'(bus.rlast), DW'(e[DW]));
                        check("r_resp", DW'(bus.rresp), DW'(e[DW+2:DW+1]));
                        check("r_id", DW'(bus.rid), DW'(e[DW+6:DW+3]));
                    end
                end
            end
            hold_v = bus.rvalid && !bus.rready;
            hold_d = bus.rdata;
        end
    end

    always @(negedge clk) begin
        logic [5:0] b;
        if (rst_n && bus.bvalid && bus.bready) begin
            if (b_q.size() == 0) check("b_unexpected", DW'(1), DW'(0));
            else begin
                b = b_q.pop_front();
                check("b_id", DW'(bus.bid), DW'(b[5:2]));
                check("b_resp", DW'(bus.bresp), DW'(b[1:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] r0;
        int            n;
        rst_n       = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.wlast   = 1'b0;
        bus.arvalid = 1'b0;
        bus.bready  = 1'b1;
        bus.awaddr  = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awid = '0;
        bus.araddr  = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arid = '0;
        bus.wdata   = '0; bus.wstrb = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", DW'(bus.awready), DW'(0));
        check("rst_arready", DW'(bus.arready), DW'(0));
        check("rst_wready", DW'(bus.wready), DW'(0));
        check("rst_bvalid", DW'(bus.bvalid), DW'(0));
        check("rst_rvalid", DW'(bus.rvalid), DW'(0));
        check("rst_rlast", DW'(bus.rlast), DW'(0));
        check("rst_resp", DW'({bus.bresp, bus.rresp}), DW'(0));
        check("rst_ids", DW'({bus.bid, bus.rid}), DW'(0));
        check("rst_rdata", bus.rdata, DW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_awready", DW'(bus.awready), DW'(1));
        check("rel_arready", DW'(bus.arready), DW'(1));
        check("rel_busy", DW'({wr_busy, rd_busy}), DW'(0));
        @(posedge clk);
        #1;

        // basic INCR write then read back: beat k carries k
        axi_write(32'h40, 8'd3, 3'd6, INCR, 4'd5, DW'(0), '1, 3);
        axi_read(32'h40, 8'd3, 3'd6, INCR, 4'd2);

        // 8-beat burst with rready toggling 1010...
        axi_write(32'd16 * 64, 8'd7, 3'd6, INCR, 4'd1, rand_word(), '1, 7);
        n = r_beats;
        rr_mode = 1;
        axi_read(32'd16 * 64, 8'd7, 3'd6, INCR, 4'd9);
        check("toggle_beats", DW'(r_beats - n), DW'(8));
        rr_mode = 0;

        // partial strobe over an all-ones word
        axi_write(32'd20 * 64, 8'd0, 3'd6, INCR, 4'd3, '1, '1, 0);
        r0 = rand_word();
        axi_write(32'd20 * 64, 8'd0, 3'd6, INCR, 4'd4, r0, 64'h0000_0000_0000_000F, 0);
        axi_read(32'd20 * 64, 8'd0, 3'd6, INCR, 4'd4);
        check("strobe_model", model[20], {{(DW-32){1'b1}}, r0[31:0]});

        // illegal size and reserved burst leave RAM untouched
        axi_write(32'd20 * 64, 8'd0, 3'd3, INCR, 4'd6, rand_word(), '1, 0);
        axi_read(32'd20 * 64, 8'd0, 3'd6, INCR, 4'd6);
        axi_read(32'd20 * 64, 8'd1, 3'd3, INCR, 4'd7);

        // FIXED read of word 7 returns four copies
        axi_write(32'd7 * 64, 8'd0, 3'd6, INCR, 4'd8, rand_word(), '1, 0);
        axi_read(32'd7 * 64, 8'd3, 3'd6, FIXED, 4'd10);
        axi_write(32'd7 * 64, 8'd0, 3'd6, 2'b11, 4'd11, rand_word(), '1, 0);
        axi_read(32'd7 * 64, 8'd0, 3'd6, INCR, 4'd12);

        // early wlast: all four beats still land, response is SLVERR
        axi_write(32'd30 * 64, 8'd3, 3'd6, INCR, 4'd13, rand_word(), '1, 1);
        axi_read(32'd30 * 64, 8'd3, 3'd6, WRAP, 4'd13);

        // reset in the middle of an 8-beat read
        mon_off     = 1;
        n           = r_beats;
        bus.araddr  = 32'd16 * 64;
        bus.arlen   = 8'd7;
        bus.arsize  = 3'd6;
        bus.arburst = INCR;
        bus.arid    = 4'd14;
        bus.arvalid = 1'b1;
        wait_ready(2, "ar_rst");
        bus.arvalid = 1'b0;
        begin
            int t = 0;
            while (r_beats < n + 3 && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("rst_mid_reach", DW'(r_beats - n), DW'(3));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", DW'(bus.rvalid), DW'(0));
        check("rst_mid_busy", DW'({wr_busy, rd_busy}), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mid_arready0", DW'(bus.arready), DW'(0));
        @(negedge clk);
        check("rst_mid_arready1", DW'(bus.arready), DW'(1));
        mon_off = 0;
        @(posedge clk);
        #1;
        axi_read(32'd16 * 64, 8'd7, 3'd6, INCR, 4'd15);

        // address aliasing and wrap past the top word
        axi_write(32'h10000, 8'd0, 3'd6, INCR, 4'd2, rand_word(), '1, 0);
        axi_read(32'h0, 8'd0, 3'd6, INCR, 4'd2);
        axi_write(32'd1022 * 64, 8'd3, 3'd6, INCR, 4'd3, rand_word(), '1, 3);
        axi_read(32'd1022 * 64, 8'd3, 3'd6, INCR, 4'd3);
        axi_read(32'h0, 8'd1, 3'd6, INCR, 4'd4);

        // random backpressure on a longer burst
        rr_mode = 2;
        axi_read(32'd16 * 64, 8'd15, 3'd6, INCR, 4'd5);
        rr_mode = 0;

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
